// File: rtl/sprite_palette_encoder_if.sv
// Pixel-stream, palette-write and sprite-RAM write bundle
// for the sprite palette encoder.
interface sprite_palette_encoder_if #(
  parameter int ADDR_W = 9,
  parameter int IDX_W  = 4
);
  logic              start;
  logic              pix_valid;
  logic [23:0]       pix_rgb;
  logic              pix_ready;
  logic              pal_we;
  logic [IDX_W-1:0]  pal_wr_idx;
  logic [23:0]       pal_wr_color;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [IDX_W-1:0]  mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_addr;
  logic [ADDR_W:0]   miss_count;

  modport slave (
    input  start, pix_valid, pix_rgb,
    input  pal_we, pal_wr_idx, pal_wr_color,
    output pix_ready, mem_we, mem_addr,
    output mem_wdata, busy, done, err,
    output err_addr, miss_count
  );

  modport master (
    output start, pix_valid, pix_rgb,
    output pal_we, pal_wr_idx, pal_wr_color,
    input  pix_ready, mem_we, mem_addr,
    input  mem_wdata, busy, done, err,
    input  err_addr, miss_count
  );
endinterface

// File: rtl/sprite_palette_encoder.sv
// RGB pixel stream -> palette index writer for sprite RAM.
// Option: SPRITE_ENC_ABORT_ON_MISS_EN stops the frame on a miss.
module sprite_palette_encoder #(
  parameter int NUM_PIXELS = 400,
  parameter int ADDR_W     = 9,
  parameter int IDX_W      = 4,
  parameter int PAL_SIZE   = 5
) (
  input logic Clk,
  input logic Reset_n,
  sprite_palette_encoder_if.slave bus
);

`ifdef SPRITE_ENC_ABORT_ON_MISS_EN
  localparam bit AbortOnMiss = 1'b1;
`else
  localparam bit AbortOnMiss = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  wdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [ADDR_W:0]   miss_q;
  logic [23:0]       pal_q [PAL_SIZE];

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              last;
  logic [ADDR_W:0]   miss_inc;

  function automatic logic [23:0] pal_rst(input int i);
    case (i)
      0:       return 24'h800080;
      1:       return 24'h000000;
      2:       return 24'hE75A10;
      3:       return 24'hFFA542;
      4:       return 24'h8C1000;
      default: return 24'h000000;
    endcase
  endfunction

  // Descending scan so the lowest matching index is left last.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = PAL_SIZE - 1; i >= 0; i--) begin
      if (bus.pix_rgb == pal_q[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign last     = (cnt_q == ADDR_W'(NUM_PIXELS - 1));
  assign miss_inc = (&miss_q) ? miss_q : miss_q + 1'b1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < PAL_SIZE; i++) begin
        pal_q[i] <= pal_rst(i);
      end
    end else if (bus.pal_we && !busy_q) begin
      for (int i = 0; i < PAL_SIZE; i++) begin
        if (bus.pal_wr_idx == IDX_W'(i)) begin
          pal_q[i] <= bus.pal_wr_color;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      miss_q     <= '0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q    <= S_LOAD;
            ready_q    <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            miss_q     <= '0;
          end
        end
        S_LOAD: begin
          if (bus.pix_valid) begin
            if (!hit) begin
              miss_q <= miss_inc;
              if (!err_q) begin
                err_q      <= 1'b1;
                err_addr_q <= cnt_q;
              end
            end
            if (AbortOnMiss && !hit) begin
              state_q <= S_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Misses fall through here with hit_idx = 0.
              we_q    <= 1'b1;
              addr_q  <= cnt_q;
              wdata_q <= hit_idx;
              if (last) begin
                state_q <= S_FLUSH;
                ready_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pix_ready  = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_addr   = err_addr_q;
  assign bus.miss_count = miss_q;

endmodule

// File: doc/sprite_palette_encoder.md
Name: sprite_palette_encoder

Overview:
Write-side counterpart of the on-chip sprite ROMs. It accepts a stream of 24-bit RGB pixels and maps each one to a 4-bit palette index by comparing it against a small programmable palette. It then writes the indices sequentially into a 4-bit-wide sprite RAM. Software or a loader uses it to build or replace sprite frames (for example, block blink frames) at run time, and the existing palette-lookup read path consumes the result unchanged.

Parameters:
NUM_PIXELS, 400, pixels per sprite frame (20x20)
ADDR_W, 9, sprite RAM address width
IDX_W, 4, palette index width
PAL_SIZE, 5, number of active palette entries (at most 2**IDX_W)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame load when idle or done
pix_valid  in  1  pixel stream valid
pix_rgb  in  24  pixel colour, 0xRRGGBB
pix_ready  out  1  encoder can accept a pixel
pal_we  in  1  palette entry write strobe
pal_wr_idx  in  IDX_W  palette entry to write
pal_wr_color  in  24  colour for that entry
mem_we  out  1  sprite RAM write enable
mem_addr  out  ADDR_W  sprite RAM write address
mem_wdata  out  IDX_W  palette index to store
busy  out  1  high in LOAD and FLUSH
done  out  1  high while in DONE
err  out  1  sticky: at least one unmatched pixel in the current frame
err_addr  out  ADDR_W  address of the first unmatched pixel
miss_count  out  ADDR_W+1  number of unmatched pixels, saturating

Behaviour:
- Reset, asynchronous and immediate:
  - state = IDLE.
  - All outputs 0.
  - Address counter 0.
  - Palette resets to 0:800080, 1:000000, 2:E75A10, 3:FFA542, 4:8C1000; unused entries 000000.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE/DONE:
  - pix_ready = 0.
  - On start: clear err, err_addr, miss_count and the address counter; go to LOAD.
  - DONE->LOAD on start re-encodes a new frame from address 0.
- LOAD:
  - pix_ready = 1.
  - A pixel is accepted on the cycle where pix_valid && pix_ready.
  - start is ignored.
- Match: combinational compare of pix_rgb against entries 0..PAL_SIZE-1. The lowest matching index wins.
- Write pipeline, latency 1:
  - On the cycle after an accept: mem_we = 1, mem_addr = counter value at accept, mem_wdata = matched index.
  - mem_we is 0 in every other cycle.
  - Back-to-back accepts give one write per cycle.
- Miss (no entry matches), default build:
  - Write index 0 (transparent).
  - miss_count += 1, saturating at 2**(ADDR_W+1)-1.
  - On the first miss of the frame: err is set and err_addr is latched. Later misses do not change err_addr.
- Counter: increments on each accept. The accept at address NUM_PIXELS-1 moves to FLUSH; the counter does not wrap past NUM_PIXELS-1.
- FLUSH:
  - pix_ready = 0.
  - The final write issues this cycle.
  - Next state DONE.
- Palette writes:
  - Honoured only when busy = 0.
  - Ignored if pal_wr_idx >= PAL_SIZE.
  - Take effect from the next cycle.
- Simultaneous start and pal_we in IDLE: both take effect. The new palette entry applies to the first pixel accepted, which is at least one cycle later.
- Reset mid-frame: mem_we drops immediately and the partial frame is abandoned. Sprite RAM contents are not restored.

Optional Feature:
SPRITE_ENC_ABORT_ON_MISS_EN
- Defined:
  - An unmatched pixel is accepted but not written (no mem_we for it).
  - err and err_addr are set and miss_count = 1.
  - State goes to DONE on the next cycle, with done = 1 and err = 1.
  - The counter holds the miss address.
- Undefined: the default substitute-and-continue behaviour above.

Test Plan:
1. Reset, start, stream 400 pixels all 0xE75A10 with pix_valid held high:
   - 400 writes, mem_addr 0..399, mem_wdata = 2.
   - done high on the cycle after the 400th write (FLUSH->DONE).
   - err = 0, miss_count = 0.
2. Gapped stream: pix_valid toggles every other cycle, colours cycle 800080, 000000, FFA542:
   - Writes only one cycle after each accept, with data 0, 1, 3 repeating.
   - Addresses contiguous.
3. Pixels at addresses 7 and 50 are 0x123456, the rest 0x8C1000:
   - Address 7 and 50 write 0; all others write 4.
   - err = 1, err_addr = 7, miss_count = 2.
   - With SPRITE_ENC_ABORT_ON_MISS_EN: writes to addresses 0..6 only, done = 1 after address 7, miss_count = 1.
4. Palette writes:
   - In IDLE, pal_we idx 3 = 0x00FF00, then encode a frame of 0x00FF00 -> all mem_wdata = 3.
   - pal_we during LOAD -> ignored.
   - pal_wr_idx = 6 -> ignored.
5. Assert Reset_n low at pixel 200:
   - mem_we, busy and pix_ready go low asynchronously.
   - After release: IDLE; a new start writes from address 0.
6. start pulse during LOAD -> ignored, address continues. start in DONE -> new frame, err and miss_count cleared.
